// File: rtl/hazard_control_unit.sv
// hazard_control_unit
// Stall and flush controller for the 5-stage pipeline. It handles the
// hazards that the bypass network cannot cover: load-use bubbles,
// instruction and data memory wait, control-flow redirects and halt.
// The latch enables and flushes are combinational from the state and
// the current inputs.
// Optional build macro HAZARD_PERF_EN adds three saturating 32-bit
// performance counters: stall_cycles, redirect_cycles and memwait_cycles.
module hazard_control_unit #(
    parameter int REG_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             idex_dmemren,
    input  logic [REG_W-1:0] idex_wsel,
    input  logic             exmem_dmemren,
    input  logic             exmem_dmemwen,
    input  logic             exmem_redirect,
    input  logic             memwb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halt
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      redirect_cycles,
    output logic [31:0]      memwait_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MEM_WAIT   = 2'd1,
        ST_REDIR_PEND = 2'd2,
        ST_HALTED     = 2'd3
    } state_t;

    // Control word layout:
    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, halt}
    localparam logic [8:0] CTRL_GO     = 9'b11111_000_0;
    localparam logic [8:0] CTRL_FREEZE = 9'b00000_000_0;
    localparam logic [8:0] CTRL_HALT   = 9'b00000_000_1;
    localparam logic [8:0] CTRL_RESET  = 9'b00000_111_0;
    localparam logic [8:0] CTRL_REDIR  = 9'b11111_111_0;
    localparam logic [8:0] CTRL_LU     = 9'b00111_010_0;
    localparam logic [8:0] CTRL_MISS   = 9'b01111_100_0;
    localparam logic [8:0] CTRL_PEND   = 9'b11111_100_0;

    state_t     state_r;
    state_t     state_next_s;
    logic [8:0] ctrl_s;
    logic       mem_busy_s;
    logic       load_use_s;

    // Hazard detection: outstanding data access and load-use dependency.
    always_comb begin
        mem_busy_s = (exmem_dmemren | exmem_dmemwen) & ~dhit;
        load_use_s = idex_dmemren
                   & (idex_wsel != {REG_W{1'b0}})
                   & ((idex_wsel == ifid_rs) | (ifid_uses_rt & (idex_wsel == ifid_rt)));
    end

    // Control word and next state; reset overrides every state.
    always_comb begin
        ctrl_s       = CTRL_GO;
        state_next_s = state_r;
        if (RST) begin
            ctrl_s       = CTRL_RESET;
            state_next_s = ST_RUN;
        end else begin
            case (state_r)
                // MEM_WAIT with dhit=1 re-evaluates as RUN; mem_busy is
                // naturally 0 then, so a pending redirect is honoured.
                ST_RUN, ST_MEM_WAIT: begin
                    if ((state_r == ST_MEM_WAIT) && !dhit) begin
                        ctrl_s       = CTRL_FREEZE;
                        state_next_s = ST_MEM_WAIT;
                    end else if (memwb_halt) begin
                        ctrl_s       = CTRL_HALT;
                        state_next_s = ST_HALTED;
                    end else if (mem_busy_s) begin
                        ctrl_s       = CTRL_FREEZE;
                        state_next_s = ST_MEM_WAIT;
                    end else if (exmem_redirect) begin
                        ctrl_s       = CTRL_REDIR;
                        state_next_s = ihit ? ST_RUN : ST_REDIR_PEND;
                    end else if (load_use_s) begin
                        ctrl_s       = CTRL_LU;
                        state_next_s = ST_RUN;
                    end else if (!ihit) begin
                        ctrl_s       = CTRL_MISS;
                        state_next_s = ST_RUN;
                    end else begin
                        ctrl_s       = CTRL_GO;
                        state_next_s = ST_RUN;
                    end
                end
                // Discard wrong-path fetches until the first completed
                // fetch, which is itself discarded.
                ST_REDIR_PEND: begin
                    if (memwb_halt) begin
                        ctrl_s       = CTRL_HALT;
                        state_next_s = ST_HALTED;
                    end else if (mem_busy_s) begin
                        ctrl_s       = CTRL_FREEZE;
                        state_next_s = ST_REDIR_PEND;
                    end else begin
                        ctrl_s       = CTRL_PEND;
                        state_next_s = ihit ? ST_RUN : ST_REDIR_PEND;
                    end
                end
                ST_HALTED: begin
                    ctrl_s       = CTRL_HALT;
                    state_next_s = ST_HALTED;
                end
                default: begin
                    ctrl_s       = CTRL_FREEZE;
                    state_next_s = ST_RUN;
                end
            endcase
        end
    end

    assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_flush, idex_flush, exmem_flush, halt} = ctrl_s;

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

`ifdef HAZARD_PERF_EN
    logic stall_evt_s;
    logic redir_evt_s;
    logic memwait_evt_s;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
        return (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
    endfunction

    // Counter events; exmem_flush outside reset only comes from a redirect.
    always_comb begin
        stall_evt_s   = !RST && !pc_en && (state_r != ST_HALTED);
        redir_evt_s   = !RST && ((state_r == ST_REDIR_PEND) || exmem_flush);
        memwait_evt_s = !RST && ((state_r == ST_MEM_WAIT) ||
                                 ((state_r == ST_RUN) && (state_next_s == ST_MEM_WAIT)));
    end

    // Saturating performance counters, cleared by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cycles    <= 32'd0;
            redirect_cycles <= 32'd0;
            memwait_cycles  <= 32'd0;
        end else begin
            stall_cycles    <= sat_inc(stall_cycles, stall_evt_s);
            redirect_cycles <= sat_inc(redirect_cycles, redir_evt_s);
            memwait_cycles  <= sat_inc(memwait_cycles, memwait_evt_s);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios with
// hand-computed control words, followed by randomized traffic checked
// cycle by cycle against a priority-list reference model.
module tb_hazard_control_unit;
    localparam int REG_W = 5;

    // Model modes
    localparam int M_RUN  = 0;
    localparam int M_WAIT = 1;
    localparam int M_PEND = 2;
    localparam int M_HALT = 3;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, halt}
    localparam logic [8:0] V_GO     = 9'b111110000;
    localparam logic [8:0] V_FREEZE = 9'b000000000;
    localparam logic [8:0] V_HALT   = 9'b000000001;
    localparam logic [8:0] V_RESET  = 9'b000001110;
    localparam logic [8:0] V_REDIR  = 9'b111111110;
    localparam logic [8:0] V_LU     = 9'b001110100;
    localparam logic [8:0] V_MISS   = 9'b011111000;
    localparam logic [8:0] V_PEND   = 9'b111111000;

    logic             CLK = 1'b0;
    logic             RST;
    logic             ihit, dhit;
    logic [REG_W-1:0] ifid_rs, ifid_rt, idex_wsel;
    logic             ifid_uses_rt, idex_dmemren;
    logic             exmem_dmemren, exmem_dmemwen, exmem_redirect, memwb_halt;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, exmem_flush, halt;
`ifdef HAZARD_PERF_EN
    logic [31:0]      stall_cycles, redirect_cycles, memwait_cycles;
    longint           m_stall, m_redir, m_wait;
`endif

    int         mode;
    int         n_checks;
    int         n_fails;
    logic [8:0] exp_v;
    int         exp_next;
    bit         exp_redir;

    always #5 CLK = ~CLK;

    hazard_control_unit #(.REG_W(REG_W)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .ihit           (ihit),
        .dhit           (dhit),
        .ifid_rs        (ifid_rs),
        .ifid_rt        (ifid_rt),
        .ifid_uses_rt   (ifid_uses_rt),
        .idex_dmemren   (idex_dmemren),
        .idex_wsel      (idex_wsel),
        .exmem_dmemren  (exmem_dmemren),
        .exmem_dmemwen  (exmem_dmemwen),
        .exmem_redirect (exmem_redirect),
        .memwb_halt     (memwb_halt),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .idex_en        (idex_en),
        .exmem_en       (exmem_en),
        .memwb_en       (memwb_en),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .exmem_flush    (exmem_flush),
        .halt           (halt)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .redirect_cycles (redirect_cycles),
        .memwait_cycles  (memwait_cycles)
`endif
    );

    task automatic chk(input string kind, input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s %s: got %0h expected %0h", kind, tag, got, want);
        end
    endtask

    // Reference model: the first true hazard in priority order picks the outcome.
    task automatic predict();
        logic       busy, lu;
        logic       conds[5];
        logic [8:0] outs[5];
        int         nxts[5];
        int         pick;
        busy = (exmem_dmemren | exmem_dmemwen) & ~dhit;
        lu   = idex_dmemren && (idex_wsel != 5'd0) &&
               ((idex_wsel == ifid_rs) || (ifid_uses_rt && (idex_wsel == ifid_rt)));
        exp_redir = 1'b0;
        pick      = -1;
        if (RST) begin
            exp_v = V_RESET; exp_next = M_RUN;
        end else if (mode == M_HALT) begin
            exp_v = V_HALT; exp_next = M_HALT;
        end else if (mode == M_WAIT && !dhit) begin
            exp_v = V_FREEZE; exp_next = M_WAIT;
        end else if (mode == M_PEND) begin
            exp_redir = 1'b1;
            if (memwb_halt) begin
                exp_v = V_HALT; exp_next = M_HALT;
            end else if (busy) begin
                exp_v = V_FREEZE; exp_next = M_PEND;
            end else begin
                exp_v = V_PEND; exp_next = ihit ? M_RUN : M_PEND;
            end
        end else begin
            conds = '{memwb_halt, busy, exmem_redirect, lu, !ihit};
            outs  = '{V_HALT, V_FREEZE, V_REDIR, V_LU, V_MISS};
            nxts  = '{M_HALT, M_WAIT, (ihit ? M_RUN : M_PEND), M_RUN, M_RUN};
            exp_v = V_GO; exp_next = M_RUN;
            for (int k = 4; k >= 0; k--) begin
                if (conds[k]) begin
                    exp_v = outs[k]; exp_next = nxts[k]; pick = k;
                end
            end
            exp_redir = (pick == 2);
        end
    endtask

    // One clock cycle: check at the falling edge, advance the model, then
    // return just after the next rising edge ready for new inputs.
    task automatic cycle(input bit use_lit, input logic [8:0] lit, input string tag);
        logic [8:0] got;
        @(negedge CLK);
        predict();
        got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, halt};
        chk("ctrl-vs-model", tag, 64'(got), 64'(exp_v));
        if (use_lit) begin
            chk("ctrl-vs-literal", tag, 64'(got), 64'(lit));
            chk("model-vs-literal", tag, 64'(exp_v), 64'(lit));
        end
`ifdef HAZARD_PERF_EN
        chk("stall_cycles", tag, 64'(stall_cycles), m_stall);
        chk("redirect_cycles", tag, 64'(redirect_cycles), m_redir);
        chk("memwait_cycles", tag, 64'(memwait_cycles), m_wait);
        if (RST) begin
            m_stall = 0; m_redir = 0; m_wait = 0;
        end else begin
            if (!exp_v[8] && mode != M_HALT && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (exp_redir && m_redir < 64'hFFFF_FFFF) m_redir++;
            if ((mode == M_WAIT || (mode == M_RUN && exp_next == M_WAIT)) && m_wait < 64'hFFFF_FFFF) m_wait++;
        end
`endif
        mode = exp_next;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_idle();
        RST = 1'b0; ihit = 1'b1; dhit = 1'b1;
        ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0;
        idex_dmemren = 1'b0; idex_wsel = 5'd0;
        exmem_dmemren = 1'b0; exmem_dmemwen = 1'b0;
        exmem_redirect = 1'b0; memwb_halt = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fails = 0; mode = M_RUN;
`ifdef HAZARD_PERF_EN
        m_stall = 0; m_redir = 0; m_wait = 0;
`endif
        set_idle();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        cycle(1'b1, V_RESET, "reset");
        set_idle();
        cycle(1'b1, V_GO, "idle");

        // Load-use on rs, clears once the load moves on
        idex_dmemren = 1'b1; idex_wsel = 5'd8; ifid_rs = 5'd8;
        cycle(1'b1, V_LU, "loaduse_rs");
        idex_dmemren = 1'b0;
        cycle(1'b1, V_GO, "loaduse_after");
        // Destination r0 never stalls
        idex_dmemren = 1'b1; idex_wsel = 5'd0; ifid_rs = 5'd0;
        cycle(1'b1, V_GO, "loaduse_r0");
        // rt dependency only counts when rt is read
        idex_wsel = 5'd9; ifid_rs = 5'd3; ifid_rt = 5'd9; ifid_uses_rt = 1'b1;
        cycle(1'b1, V_LU, "loaduse_rt");
        ifid_uses_rt = 1'b0;
        cycle(1'b1, V_GO, "loaduse_rt_unused");
        set_idle();

        // Data wait: three frozen cycles, then release
        exmem_dmemren = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b1, V_FREEZE, "dwait");
        dhit = 1'b1;
        cycle(1'b1, V_GO, "dwait_release");
        set_idle();
        cycle(1'b1, V_GO, "dwait_run");

        // Redirect with two fetch misses
        exmem_redirect = 1'b1; ihit = 1'b0;
        cycle(1'b1, V_REDIR, "redir_c0");
        exmem_redirect = 1'b0;
        cycle(1'b1, V_PEND, "redir_pend");
        ihit = 1'b1;
        cycle(1'b1, V_PEND, "redir_first_hit");
        cycle(1'b1, V_GO, "redir_run");
        // Redirect with an immediate hit stays in RUN
        exmem_redirect = 1'b1;
        cycle(1'b1, V_REDIR, "redir_hit");
        exmem_redirect = 1'b0;
        cycle(1'b1, V_GO, "redir_hit_run");

        // Fetch miss alone
        ihit = 1'b0;
        cycle(1'b1, V_MISS, "imiss");
        set_idle();

        // mem_busy outranks load_use; the bubble appears on release
        exmem_dmemwen = 1'b1; dhit = 1'b0;
        idex_dmemren = 1'b1; idex_wsel = 5'd8; ifid_rs = 5'd8;
        cycle(1'b1, V_FREEZE, "prio_freeze");
        dhit = 1'b1;
        cycle(1'b1, V_LU, "prio_release");
        set_idle();
        cycle(1'b1, V_GO, "prio_run");

        // Halt outranks mem_busy and is sticky
        memwb_halt = 1'b1; exmem_dmemren = 1'b1; dhit = 1'b0;
        cycle(1'b1, V_HALT, "halt_entry");
        set_idle();
        ihit = 1'b0; exmem_redirect = 1'b1;
        cycle(1'b1, V_HALT, "halt_sticky1");
        cycle(1'b1, V_HALT, "halt_sticky2");
        RST = 1'b1;
        cycle(1'b1, V_RESET, "halt_reset");
`ifdef HAZARD_PERF_EN
        chk("stall_after_rst", "lit", 64'(stall_cycles), 64'd0);
        chk("redir_after_rst", "lit", 64'(redirect_cycles), 64'd0);
        chk("wait_after_rst", "lit", 64'(memwait_cycles), 64'd0);
`endif
        set_idle();
        cycle(1'b1, V_GO, "after_reset");

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            RST            = ($urandom_range(0, 59) == 0);
            ihit           = ($urandom_range(0, 3) != 0);
            dhit           = ($urandom_range(0, 2) != 0);
            ifid_rs        = REG_W'($urandom_range(0, 3));
            ifid_rt        = REG_W'($urandom_range(0, 3));
            idex_wsel      = REG_W'($urandom_range(0, 3));
            ifid_uses_rt   = ($urandom_range(0, 1) != 0);
            idex_dmemren   = ($urandom_range(0, 2) == 0);
            exmem_dmemren  = ($urandom_range(0, 3) == 0);
            exmem_dmemwen  = ($urandom_range(0, 5) == 0);
            exmem_redirect = ($urandom_range(0, 7) == 0);
            memwb_halt     = ($urandom_range(0, 49) == 0);
            cycle(1'b0, V_GO, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
